// File: rtl/sub_serial16.sv
// sub_serial16: bit-serial 16-bit subtractor (A + ~B + 1, LSB first) with borrow/overflow/zero flags; ports clk, rst, i_start, i_a, i_b -> o_busy, o_done, o_res, o_borrow, o_ovf, o_zero
module sub_serial16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_res,
  output logic        o_borrow,
  output logic        o_ovf,
  output logic        o_zero
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]  state;
  logic [15:0] a, b;
  logic [3:0]  k;
  logic        c, bn, sum, cout;
  logic [15:0] res_next;
  assign bn       = ~b[k];
  assign sum      = a[k] ^ bn ^ c;
  assign cout     = (a[k] & bn) | (a[k] & c) | (bn & c);
  // result shifts in from the MSB so that after 16 steps bit k sits at position k
  assign res_next = {sum, o_res[15:1]};
  assign o_busy   = state == RUN;
  assign o_done   = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      k        <= '0;
      c        <= 1'b0;
      o_res    <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
      o_zero   <= 1'b0;
    end else if (state != RUN && i_start) begin
      state <= RUN;
      a     <= i_a;
      b     <= i_b;
      k     <= '0;
      c     <= 1'b1;
    end else if (state == RUN) begin
      o_res <= res_next;
      c     <= cout;
      k     <= k + 4'd1;
      if (k == 4'd15) begin
        state    <= DONE;
        o_borrow <= ~cout;
        o_ovf    <= (a[15] ^ b[15]) & (sum ^ a[15]);
        o_zero   <= res_next == '0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sub_serial16.sv
// tb_sub_serial16: self-checking bench for sub_serial16 with directed and randomized operands
module tb_sub_serial16;
  logic        clk = 0, rst = 0, i_start = 0;
  logic [15:0] i_a = 0, i_b = 0;
  logic        o_busy, o_done, o_borrow, o_ovf, o_zero;
  logic [15:0] o_res;
  int cmp = 0, err = 0;

  sub_serial16 dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_res(o_res),
    .o_borrow(o_borrow), .o_ovf(o_ovf), .o_zero(o_zero)
  );

  always #5 clk = ~clk;

  localparam int ND = 8;
  localparam logic [15:0] TA [ND] = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'hA5A5, 16'h0000, 16'hFFFF, 16'h0000};
  localparam logic [15:0] TB [ND] = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'hA5A5, 16'hFFFF, 16'h0000, 16'h0000};
  localparam logic [15:0] TR [ND] = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
  // {borrow, ovf, zero}
  localparam logic [2:0]  TF [ND] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b100, 3'b000, 3'b001};

  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int d;
    logic [15:0] r;
    d = int'($signed(a)) - int'($signed(b));
    r = 16'((int'(a) - int'(b)) & 32'hFFFF);
    return {r, a < b, (d > 32767) || (d < -32768), r == 16'h0};
  endfunction

  task automatic do_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_start = 1; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_start = 0; i_a = 16'($urandom); i_b = 16'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_done && n < 40);
  endtask

  task automatic test_reset;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    cmp++;
    if ({o_busy, o_done, o_res, o_borrow, o_ovf, o_zero} !== 21'h0) begin
      err++; $display("FAIL reset_outputs got=%h want=0", {o_busy, o_done, o_res, o_borrow, o_ovf, o_zero});
    end
    rst = 0;
  endtask

  task automatic test_directed;
    int n;
    for (int i = 0; i < ND; i++) begin
      do_start(TA[i], TB[i]);
      cmp++;
      if (o_busy !== 1'b1) begin err++; $display("FAIL dir_busy[%0d] got=%b want=1", i, o_busy); end
      wait_done(n);
      cmp++;
      if (n != 16) begin err++; $display("FAIL dir_latency[%0d] done_after_edges=%0d want=16", i, n); end
      cmp++;
      if ({o_res, o_borrow, o_ovf, o_zero} !== {TR[i], TF[i]}) begin
        err++; $display("FAIL dir_result[%0d] got=%h/%b want=%h/%b", i, o_res, {o_borrow, o_ovf, o_zero}, TR[i], TF[i]);
      end
      repeat (3) @(negedge clk);
      cmp++;
      if ({o_done, o_busy, o_res, o_borrow, o_ovf, o_zero} !== {2'b00, TR[i], TF[i]}) begin
        err++; $display("FAIL dir_hold[%0d] got=%b%b %h/%b want=00 %h/%b", i, o_done, o_busy, o_res, {o_borrow, o_ovf, o_zero}, TR[i], TF[i]);
      end
    end
  endtask

  task automatic test_random;
    int n;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i % 8 == 0) b = a;
      do_start(a, b);
      wait_done(n);
      cmp++;
      if (n != 16 || {o_res, o_borrow, o_ovf, o_zero} !== model(a, b)) begin
        err++; $display("FAIL rand[%0d] a=%h b=%h edges=%0d got=%h want=%h", i, a, b, n, {o_res, o_borrow, o_ovf, o_zero}, model(a, b));
      end
    end
  endtask

  task automatic test_busy_ignore;
    int n, pulses;
    logic [15:0] a, b;
    a = 16'h1234; b = 16'h4321;
    do_start(a, b);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    i_start = 1; i_a = 16'hFFFF; i_b = 16'h0001;
    @(posedge clk); #1;
    i_start = 0;
    wait_done(n);
    cmp++;
    if (n + 5 != 16) begin err++; $display("FAIL busy_latency edges=%0d want=16", n + 5); end
    cmp++;
    if ({o_res, o_borrow, o_ovf, o_zero} !== model(a, b)) begin
      err++; $display("FAIL busy_result got=%h want=%h", {o_res, o_borrow, o_ovf, o_zero}, model(a, b));
    end
    pulses = 0;
    repeat (24) begin @(posedge clk); #1; if (o_done) pulses++; end
    cmp++;
    if (pulses != 0) begin err++; $display("FAIL busy_extra_done pulses=%0d want=0", pulses); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] a1, b1, a2, b2;
    a1 = 16'h0F0F; b1 = 16'hF0F0; a2 = 16'h8000; b2 = 16'h7FFF;
    do_start(a1, b1);
    wait_done(n);
    cmp++;
    if ({o_res, o_borrow, o_ovf, o_zero} !== model(a1, b1)) begin
      err++; $display("FAIL b2b_first got=%h want=%h", {o_res, o_borrow, o_ovf, o_zero}, model(a1, b1));
    end
    i_start = 1; i_a = a2; i_b = b2;
    @(posedge clk); #1;
    i_start = 0;
    cmp++;
    if ({o_busy, o_done} !== 2'b10) begin err++; $display("FAIL b2b_restart busy_done=%b%b want=10", o_busy, o_done); end
    wait_done(n);
    cmp++;
    if (n != 16 || {o_res, o_borrow, o_ovf, o_zero} !== model(a2, b2)) begin
      err++; $display("FAIL b2b_second edges=%0d got=%h want=%h", n, {o_res, o_borrow, o_ovf, o_zero}, model(a2, b2));
    end
  endtask

  task automatic test_reset_midop;
    int n, pulses;
    do_start(16'hBEEF, 16'h1234);
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1;
    #1;
    cmp++;
    if ({o_busy, o_done, o_res, o_borrow, o_ovf, o_zero} !== 21'h0) begin
      err++; $display("FAIL midop_reset got=%h want=0", {o_busy, o_done, o_res, o_borrow, o_ovf, o_zero});
    end
    @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (24) begin @(posedge clk); #1; if (o_done || o_busy) pulses++; end
    cmp++;
    if (pulses != 0) begin err++; $display("FAIL midop_no_done active_cycles=%0d want=0", pulses); end
    do_start(16'h0001, 16'h0001);
    wait_done(n);
    cmp++;
    if (n != 16 || {o_res, o_borrow, o_ovf, o_zero} !== {16'h0000, 3'b001}) begin
      err++; $display("FAIL midop_restart edges=%0d got=%h want=%h", n, {o_res, o_borrow, o_ovf, o_zero}, {16'h0000, 3'b001});
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_busy_ignore;
    test_back_to_back;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
